// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle controller and the byte-fetch datapath.
// master = controller side, slave = datapath/memory side.
interface mc_ctrl_fsm_if #(
   parameter int FETCH_BEATS = 4,
   parameter int FW          = 3
);
   logic [5:0]             op;
   logic [FW-1:0]          funct;
   logic                   zero;
   logic                   memready;

   logic                   memread;
   logic                   memwrite;
   logic                   iord;
   logic [FETCH_BEATS-1:0] irwrite;
   logic                   pcen;
   logic [1:0]             pcsrc;
   logic                   alusrca;
   logic [1:0]             alusrcb;
   logic [FW-1:0]          alucontrol;
   logic                   regwrite;
   logic                   regdst;
   logic                   memtoreg;
   logic                   illegal;
   logic [3:0]             state;

   modport master (
      input  op, funct, zero, memready,
      output memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
             alucontrol, regwrite, regdst, memtoreg, illegal, state
   );

   modport slave (
      output op, funct, zero, memready,
      input  memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
             alucontrol, regwrite, regdst, memtoreg, illegal, state
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: multi-beat instruction fetch with memready handshake,
// opcode decode, BEQ/BNE resolution and a sticky illegal-opcode trap.
module mc_ctrl_fsm #(
   parameter int FETCH_BEATS = 4,
   parameter int FW          = 3
) (
   input  logic          clk,
   input  logic          reset,
   mc_ctrl_fsm_if.master bus
);

   localparam int BEAT_W = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FETCH_BEATS - 1);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_ADDIEX = 4'd8;
   localparam logic [3:0] S_ADDIWB = 4'd9;
   localparam logic [3:0] S_BRANCH = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_TRAP   = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [FW-1:0] ALU_ADD = FW'(3'b010);
   localparam logic [FW-1:0] ALU_SUB = FW'(3'b110);

   logic [3:0]        state_q,   state_d;
   logic [BEAT_W-1:0] beat_q,    beat_d;
   logic              illegal_q, illegal_d;

   // Next-state logic; memready only matters in the three memory states.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH: begin
            if (bus.memready) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = S_DECODE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW:    state_d = S_MEMADR;
               OP_RTYPE:        state_d = S_EXEC;
               OP_ADDI:         state_d = S_ADDIEX;
               OP_BEQ, OP_BNE:  state_d = S_BRANCH;
               OP_J:            state_d = S_JUMP;
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (bus.memready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (bus.memready) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         beat_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         illegal_q <= illegal_d;
      end
   end

   // Output decode; everything is held low while reset is asserted.
   always_comb begin
      bus.memread    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.iord       = 1'b0;
      bus.irwrite    = '0;
      bus.pcen       = 1'b0;
      bus.pcsrc      = 2'b00;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.alucontrol = '0;
      bus.regwrite   = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.illegal    = 1'b0;
      bus.state      = 4'd0;
      if (!reset) begin
         bus.state      = state_q;
         bus.alucontrol = ALU_ADD;
         case (state_q)
            S_FETCH: begin
               bus.memread = 1'b1;
               if (bus.memready) begin
                  bus.irwrite = FETCH_BEATS'(1) << beat_q;
                  bus.alusrcb = 2'b01;
                  bus.pcen    = 1'b1;
               end
            end
            S_DECODE: bus.alusrcb = 2'b11;
            S_MEMADR: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'b10;
            end
            S_MEMRD: begin
               bus.memread = 1'b1;
               bus.iord    = 1'b1;
            end
            S_MEMWB: begin
               bus.regwrite = 1'b1;
               bus.memtoreg = 1'b1;
            end
            S_MEMWR: begin
               bus.memwrite = 1'b1;
               bus.iord     = 1'b1;
            end
            S_EXEC: begin
               bus.alusrca    = 1'b1;
               bus.alucontrol = bus.funct;
            end
            S_ALUWB: begin
               bus.regwrite = 1'b1;
               bus.regdst   = 1'b1;
            end
            S_ADDIEX: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'b10;
            end
            S_ADDIWB: bus.regwrite = 1'b1;
            S_BRANCH: begin
               bus.alusrca    = 1'b1;
               bus.alucontrol = ALU_SUB;
               bus.pcsrc      = 2'b01;
               bus.pcen       = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
            end
            S_JUMP: begin
               bus.pcsrc = 2'b10;
               bus.pcen  = 1'b1;
            end
            S_TRAP: begin
               bus.alucontrol = '0;
               bus.illegal    = illegal_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: a 4-beat and a 1-beat build, expected
// per-cycle outputs queued at drive time and checked at the falling edge.
module tb_mc_ctrl_fsm;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   typedef struct packed {
      logic [3:0] state;
      logic       memread;
      logic       memwrite;
      logic       iord;
      logic [3:0] irwrite;
      logic       pcen;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucontrol;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       illegal;
   } outs_t;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   outs_t sb[$];
   string tq[$];

   always #5 clk = ~clk;

   mc_ctrl_fsm_if #(.FETCH_BEATS(4), .FW(3)) bus4 ();
   mc_ctrl_fsm_if #(.FETCH_BEATS(1), .FW(3)) bus1 ();

   mc_ctrl_fsm #(.FETCH_BEATS(4), .FW(3)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
   mc_ctrl_fsm #(.FETCH_BEATS(1), .FW(3)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   // Expected outputs for a given state/beat and current inputs.
   function automatic outs_t model(input logic rst, input logic [3:0] st, input int beat,
                                   input logic rdy, input logic [5:0] opc,
                                   input logic [2:0] fn, input logic z);
      outs_t e = '0;
      if (rst) return e;
      e.state = st;
      e.alucontrol = 3'b010;
      case (st)
         4'd0: begin
            e.memread = 1'b1;
            if (rdy) begin
               e.irwrite = 4'(1 << beat);
               e.alusrcb = 2'b01;
               e.pcen    = 1'b1;
            end
         end
         4'd1:  e.alusrcb = 2'b11;
         4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         4'd3:  begin e.memread = 1'b1; e.iord = 1'b1; end
         4'd4:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
         4'd5:  begin e.memwrite = 1'b1; e.iord = 1'b1; end
         4'd6:  begin e.alusrca = 1'b1; e.alucontrol = fn; end
         4'd7:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
         4'd8:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         4'd9:  e.regwrite = 1'b1;
         4'd10: begin
            e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
            e.pcen = (opc == OP_BNE) ? ~z : z;
         end
         4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
         4'd12: begin e.alucontrol = 3'b000; e.illegal = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic outs_t obs4();
      return '{bus4.state, bus4.memread, bus4.memwrite, bus4.iord, bus4.irwrite, bus4.pcen,
               bus4.pcsrc, bus4.alusrca, bus4.alusrcb, bus4.alucontrol, bus4.regwrite,
               bus4.regdst, bus4.memtoreg, bus4.illegal};
   endfunction

   function automatic outs_t obs1();
      return '{bus1.state, bus1.memread, bus1.memwrite, bus1.iord, {3'b000, bus1.irwrite},
               bus1.pcen, bus1.pcsrc, bus1.alusrca, bus1.alusrcb, bus1.alucontrol,
               bus1.regwrite, bus1.regdst, bus1.memtoreg, bus1.illegal};
   endfunction

   task automatic check(input int sel);
      outs_t exp, got;
      string tg;
      exp = sb.pop_front();
      tg  = tq.pop_front();
      got = (sel == 1) ? obs1() : obs4();
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tg, got, exp);
      end
   endtask

   // One clock cycle: drive memready, queue expectation, check at negedge.
   task automatic step(input int sel, input string tag, input logic rdy,
                       input logic [3:0] st, input int beat);
      if (sel == 1) begin
         bus1.memready = rdy;
         sb.push_back(model(reset, st, beat, rdy, bus1.op, bus1.funct, bus1.zero));
      end else begin
         bus4.memready = rdy;
         sb.push_back(model(reset, st, beat, rdy, bus4.op, bus4.funct, bus4.zero));
      end
      tq.push_back(tag);
      @(negedge clk);
      check(sel);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch4(input string tag);
      for (int b = 0; b < 4; b++) step(4, $sformatf("%s_f%0d", tag, b), 1'b1, 4'd0, b);
   endtask

   initial begin
      reset = 1'b1;
      bus4.op = OP_RTYPE; bus4.funct = 3'b000; bus4.zero = 1'b0; bus4.memready = 1'b0;
      bus1.op = OP_J;     bus1.funct = 3'b000; bus1.zero = 1'b0; bus1.memready = 1'b1;
      @(posedge clk);
      #1;

      // Reset with a coincident memready pulse: outputs forced low, pulse discarded
      step(4, "rst_a", 1'b1, 4'd0, 0);
      step(4, "rst_b", 1'b1, 4'd0, 0);
      reset = 1'b0;

      // RTYPE, funct=100
      bus4.op = OP_RTYPE; bus4.funct = 3'b100;
      fetch4("rt");
      step(4, "rt_dec",   1'b1, 4'd1, 0);
      step(4, "rt_exec",  1'b1, 4'd6, 0);
      step(4, "rt_aluwb", 1'b1, 4'd7, 0);

      // LW with three wait cycles in MEMRD; memready low in DECODE/MEMADR is ignored
      bus4.op = OP_LW;
      fetch4("lw");
      step(4, "lw_dec",    1'b0, 4'd1, 0);
      step(4, "lw_memadr", 1'b0, 4'd2, 0);
      for (int i = 0; i < 3; i++) step(4, $sformatf("lw_memrd_w%0d", i), 1'b0, 4'd3, 0);
      step(4, "lw_memrd",  1'b1, 4'd3, 0);
      step(4, "lw_memwb",  1'b1, 4'd4, 0);

      // SW with a fetch stall and a MEMWR stall
      bus4.op = OP_SW;
      step(4, "sw_f0_wait", 1'b0, 4'd0, 0);
      fetch4("sw");
      step(4, "sw_dec",     1'b1, 4'd1, 0);
      step(4, "sw_memadr",  1'b1, 4'd2, 0);
      step(4, "sw_memwr_w", 1'b0, 4'd5, 0);
      step(4, "sw_memwr",   1'b1, 4'd5, 0);

      // Branches
      bus4.op = OP_BEQ; bus4.zero = 1'b1;
      fetch4("beq1");
      step(4, "beq1_dec", 1'b1, 4'd1, 0);
      step(4, "beq1_br",  1'b1, 4'd10, 0);
      bus4.op = OP_BNE;
      fetch4("bne1");
      step(4, "bne1_dec", 1'b1, 4'd1, 0);
      step(4, "bne1_br",  1'b1, 4'd10, 0);
      bus4.zero = 1'b0;
      step(4, "bne0_f0", 1'b1, 4'd0, 0);
      step(4, "bne0_f1", 1'b1, 4'd0, 1);
      step(4, "bne0_f2", 1'b1, 4'd0, 2);
      step(4, "bne0_f3", 1'b1, 4'd0, 3);
      step(4, "bne0_dec", 1'b1, 4'd1, 0);
      step(4, "bne0_br",  1'b1, 4'd10, 0);
      bus4.op = OP_BEQ;
      fetch4("beq0");
      step(4, "beq0_dec", 1'b1, 4'd1, 0);
      step(4, "beq0_br",  1'b1, 4'd10, 0);

      // ADDI and J
      bus4.op = OP_ADDI;
      fetch4("addi");
      step(4, "addi_dec", 1'b1, 4'd1, 0);
      step(4, "addi_ex",  1'b1, 4'd8, 0);
      step(4, "addi_wb",  1'b1, 4'd9, 0);
      bus4.op = OP_J;
      fetch4("j4");
      step(4, "j4_dec",  1'b1, 4'd1, 0);
      step(4, "j4_jump", 1'b1, 4'd11, 0);

      // SW interrupted by reset on fetch beat 2
      bus4.op = OP_SW;
      step(4, "swr_f0", 1'b1, 4'd0, 0);
      step(4, "swr_f1", 1'b1, 4'd0, 1);
      reset = 1'b1;
      step(4, "swr_rst", 1'b1, 4'd0, 2);
      reset = 1'b0;
      step(4, "swr_after_f0", 1'b0, 4'd0, 0);

      // Illegal opcode traps and stays trapped regardless of inputs
      bus4.op = OP_BAD;
      fetch4("bad");
      step(4, "bad_dec", 1'b1, 4'd1, 0);
      for (int i = 0; i < 20; i++) begin
         bus4.zero = 1'($urandom_range(0, 1));
         step(4, $sformatf("trap_%0d", i), 1'($urandom_range(0, 1)), 4'd12, 0);
      end
      reset = 1'b1;
      step(4, "trap_rst", 1'b1, 4'd0, 0);
      reset = 1'b0;
      bus4.op = OP_RTYPE;
      step(4, "trap_after_f0", 1'b1, 4'd0, 0);
      step(4, "trap_after_f1", 1'b1, 4'd0, 1);

      // Single-beat build: J
      reset = 1'b1;
      bus1.op = OP_J;
      step(1, "j1_rst", 1'b1, 4'd0, 0);
      reset = 1'b0;
      step(1, "j1_f0",   1'b1, 4'd0, 0);
      step(1, "j1_dec",  1'b1, 4'd1, 0);
      step(1, "j1_jump", 1'b1, 4'd11, 0);
      step(1, "j1_next", 1'b1, 4'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
